// File: rtl/wb_spi_pkg.sv
// Shared definitions for the Wishbone-to-SPI register interface: register map,
// STATUS bit positions and FSM/decode encodings.
package wb_spi_pkg;

  localparam logic [31:0] OFS_DATA   = 32'h0000_0010;
  localparam logic [31:0] OFS_CMD    = 32'h0000_0020;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0030;

  localparam int unsigned STATUS_TO_BIT    = 0;
  localparam int unsigned STATUS_UNMAP_BIT = 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    RegData,
    RegCmd,
    RegStatus,
    RegNone
  } reg_e;

endpackage

// File: rtl/wb_spi_timeout.sv
// Wait-cycle counter for stalled SPI core accesses; saturates at TIMEOUT and
// flags expiry. TIMEOUT of 0 never expires.
module wb_spi_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_max;

  assign at_max    = (cnt_q == CntW'(TIMEOUT));
  assign expired_o = (TIMEOUT != 0) && at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_max) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_spi_regif.sv
// Wishbone classic slave exposing DATA/CMD/STATUS of the SPI core. Holds the bus
// until the core acks, or ends the cycle with wb_err after a programmable timeout.
module wb_spi_regif
  import wb_spi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned DOUT_W    = 11,
  parameter int unsigned DIN_W     = 9,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       wb_addr_i,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  input  logic [31:0]       wb_dout_i,
  output logic [31:0]       wb_din_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [DOUT_W-1:0] dout_o,
  output logic              cmd_o,
  output logic              wr_o,
  output logic              rd_o,
  input  logic [DIN_W-1:0]  din_i,
  input  logic              ack_i
);

  state_e            state_q, state_d;
  reg_e              reg_q, reg_d, req_reg;
  logic              we_q, we_d;
  logic [DOUT_W-1:0] dout_q, dout_d;
  logic [31:0]       wb_din_q, wb_din_d;
  logic              wb_ack_q, wb_ack_d;
  logic              wb_err_q, wb_err_d;
  logic              cmd_q, cmd_d, wr_q, wr_d, rd_q, rd_d;
  logic [1:0]        flags_q, flags_d, flag_set, flag_clr;
  logic              to_clr, to_en, to_expired;
  logic [31:0]       core_rdata;

  wb_spi_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (to_clr),
    .en_i     (to_en),
    .expired_o(to_expired)
  );

  // CMD is write-only; a CMD read falls through to the unmapped path.
  always_comb begin
    if (wb_addr_i == ADDR_BASE + OFS_DATA) begin
      req_reg = RegData;
    end else if (wb_addr_i == ADDR_BASE + OFS_CMD) begin
      req_reg = wb_we_i ? RegCmd : RegNone;
    end else if (wb_addr_i == ADDR_BASE + OFS_STATUS) begin
      req_reg = RegStatus;
    end else begin
      req_reg = RegNone;
    end
  end

  assign core_rdata = (reg_q == RegData && !we_q) ? {{(32 - DIN_W){1'b0}}, din_i} : 32'h0;

  always_comb begin
    state_d  = state_q;
    reg_d    = reg_q;
    we_d     = we_q;
    dout_d   = dout_q;
    wb_din_d = wb_din_q;
    wb_ack_d = 1'b0;
    wb_err_d = 1'b0;
    cmd_d    = 1'b0;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    flag_set = 2'b00;
    flag_clr = 2'b00;
    to_clr   = 1'b0;
    to_en    = 1'b0;

    case (state_q)
      StIdle: begin
        to_clr = 1'b1;
        if (wb_cyc_i && wb_stb_i) begin
          we_d   = wb_we_i;
          reg_d  = req_reg;
          dout_d = wb_dout_i[DOUT_W-1:0];
          unique case (req_reg)
            RegData: begin
              state_d = StIssue;
              wr_d    = wb_we_i;
              rd_d    = !wb_we_i;
            end
            RegCmd: begin
              state_d = StIssue;
              cmd_d   = 1'b1;
            end
            RegStatus: begin
              state_d  = StResp;
              wb_ack_d = 1'b1;
              wb_din_d = wb_we_i ? 32'h0 : {30'b0, flags_q};
              if (wb_we_i) flag_clr = wb_dout_i[1:0];
            end
            RegNone: begin
              state_d  = StResp;
              wb_ack_d = 1'b1;
              wb_din_d = 32'h0;
              flag_set[STATUS_UNMAP_BIT] = 1'b1;
            end
          endcase
        end
      end
      StIssue, StWait: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (ack_i) begin
          state_d  = StResp;
          wb_ack_d = 1'b1;
          wb_din_d = core_rdata;
        end else if (state_q == StIssue) begin
          state_d = StWait;
          to_clr  = 1'b1;
        end else if (to_expired) begin
          state_d  = StResp;
          wb_err_d = 1'b1;
          wb_din_d = 32'h0;
          flag_set[STATUS_TO_BIT] = 1'b1;
        end else begin
          to_en = 1'b1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A flag set outranks a same-cycle W1C clear.
    flags_d = (flags_q & ~flag_clr) | flag_set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      reg_q    <= RegNone;
      we_q     <= 1'b0;
      dout_q   <= '0;
      wb_din_q <= 32'h0;
      wb_ack_q <= 1'b0;
      wb_err_q <= 1'b0;
      cmd_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      flags_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      reg_q    <= reg_d;
      we_q     <= we_d;
      dout_q   <= dout_d;
      wb_din_q <= wb_din_d;
      wb_ack_q <= wb_ack_d;
      wb_err_q <= wb_err_d;
      cmd_q    <= cmd_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      flags_q  <= flags_d;
    end
  end

  assign wb_din_o = wb_din_q;
  assign wb_ack_o = wb_ack_q;
  assign wb_err_o = wb_err_q;
  assign dout_o   = dout_q;
  assign cmd_o    = cmd_q;
  assign wr_o     = wr_q;
  assign rd_o     = rd_q;

endmodule

// File: tb/tb_wb_spi_regif.sv
// Randomised bench for wb_spi_regif: a transaction-level model predicts every
// output per cycle from the documented latencies; directed cases pin the model.
module tb_wb_spi_regif;

  localparam int unsigned DoutW = 11;
  localparam int unsigned DinW  = 9;
  localparam int unsigned Tmo   = 4;
  localparam logic [31:0] Base  = 32'h0000_0000;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [31:0]      wb_addr_i, wb_dout_i, wb_din_o;
  logic             wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, wb_err_o;
  logic [DoutW-1:0] dout_o;
  logic             cmd_o, wr_o, rd_o;
  logic [DinW-1:0]  din_i;
  logic             ack_i;

  always #5 clk_i = ~clk_i;

  wb_spi_regif #(
    .ADDR_BASE(Base),
    .DOUT_W   (DoutW),
    .DIN_W    (DinW),
    .TIMEOUT  (Tmo)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wb_addr_i(wb_addr_i),
    .wb_we_i  (wb_we_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_dout_i(wb_dout_i),
    .wb_din_o (wb_din_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .dout_o   (dout_o),
    .cmd_o    (cmd_o),
    .wr_o     (wr_o),
    .rd_o     (rd_o),
    .din_i    (din_i),
    .ack_i    (ack_i)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: expected pulses for the current cycle plus held values.
  logic             e_wr, e_rd, e_cmd, e_ack, e_err;
  logic [31:0]      m_din;
  logic [DoutW-1:0] m_dout;
  logic             m_to, m_unmap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("wb_ack", 32'(wb_ack_o), 32'(e_ack));
      chk("wb_err", 32'(wb_err_o), 32'(e_err));
      chk("wr", 32'(wr_o), 32'(e_wr));
      chk("rd", 32'(rd_o), 32'(e_rd));
      chk("cmd", 32'(cmd_o), 32'(e_cmd));
      chk("wb_din", wb_din_o, m_din);
      chk("dout", 32'(dout_o), 32'(m_dout));
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    wb_cyc_i  = 1'b0;
    wb_stb_i  = 1'b0;
    wb_we_i   = 1'b0;
    wb_addr_i = $urandom;
    wb_dout_i = $urandom;
    ack_i     = 1'b0;
    din_i     = DinW'($urandom);
    {e_wr, e_rd, e_cmd, e_ack, e_err} = 5'b0;
  endtask

  // Called at the start of an IDLE cycle; returns at the start of the next one.
  // k: core ack k cycles after the strobe (<0 = never). abort_at: cycle with cyc low.
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] data,
                        input int k, input int abort_at, input logic [DinW-1:0] cdin,
                        output int term_at);
    bit is_data, is_cmd, is_stat, mapped, is_err, aborted;
    int last;
    is_data = (addr == Base + 32'h10);
    is_cmd  = (addr == Base + 32'h20) && we;
    is_stat = (addr == Base + 32'h30);
    mapped  = is_data || is_cmd;
    is_err  = mapped && !(k >= 0 && k <= int'(Tmo) + 1);
    if (!mapped) term_at = 1;
    else if (!is_err) term_at = 2 + k;
    else term_at = 3 + int'(Tmo);
    aborted = mapped && abort_at > 0 && abort_at < term_at;
    last    = aborted ? ((k >= 0 && 1 + k > abort_at) ? 1 + k : abort_at) : term_at;

    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    wb_we_i   = we;
    wb_addr_i = addr;
    wb_dout_i = data;
    {e_wr, e_rd, e_cmd, e_ack, e_err} = 5'b0;
    for (int t = 1; t <= last; t++) begin
      next_cycle();
      wb_cyc_i = aborted ? (t < abort_at) : 1'b1;
      wb_stb_i = wb_cyc_i;
      ack_i    = mapped && k >= 0 && t == 1 + k;
      din_i    = ack_i ? cdin : DinW'($urandom);
      e_wr     = (t == 1) && is_data && we;
      e_rd     = (t == 1) && is_data && !we;
      e_cmd    = (t == 1) && is_cmd;
      e_ack    = !aborted && t == term_at && !is_err;
      e_err    = !aborted && t == term_at && is_err;
      if (t == 1) m_dout = data[DoutW-1:0];
      if (!aborted && t == term_at) begin
        if (is_err) m_din = 32'h0;
        else if (is_stat && !we) m_din = {30'b0, m_unmap, m_to};
        else if (is_data && !we) m_din = 32'(cdin);
        else m_din = 32'h0;
        if (!mapped && !is_stat) m_unmap = 1'b1;
        if (is_stat && we) begin
          m_to    = m_to & ~data[0];
          m_unmap = m_unmap & ~data[1];
        end
        if (is_err) m_to = 1'b1;
      end
    end
    next_cycle();
    set_idle();
  endtask

  initial begin
    int term;
    logic [31:0] addr;
    int sel, k, ab;

    rst_i   = 1'b1;
    set_idle();
    m_din   = 32'h0;
    m_dout  = '0;
    m_to    = 1'b0;
    m_unmap = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_en = 1'b1;
    next_cycle();
    rst_i = 1'b0;

    // DATA write, core acks in the strobe cycle.
    do_txn(Base + 32'h10, 1'b1, 32'hFFFF_F5A5, 0, 0, 9'h000, term);
    chk("lit_term_wr0", 32'(term), 32'd2);
    chk("lit_dout_5a5", 32'(dout_o), 32'h5A5);

    // DATA read, three wait cycles.
    do_txn(Base + 32'h10, 1'b0, 32'h0, 3, 0, 9'h1C3, term);
    chk("lit_term_rd3", 32'(term), 32'd5);
    chk("lit_din_1c3", wb_din_o, 32'h0000_01C3);

    // Timeout, then STATUS read/W1C/read.
    do_txn(Base + 32'h10, 1'b1, 32'h0000_0123, -1, 0, 9'h0, term);
    chk("lit_term_to", 32'(term), 32'd7);
    do_txn(Base + 32'h30, 1'b0, 32'h0, 0, 0, 9'h0, term);
    chk("lit_status_to", wb_din_o, 32'h1);
    do_txn(Base + 32'h30, 1'b1, 32'h1, 0, 0, 9'h0, term);
    do_txn(Base + 32'h30, 1'b0, 32'h0, 0, 0, 9'h0, term);
    chk("lit_status_clr", wb_din_o, 32'h0);

    // Unmapped read.
    do_txn(Base + 32'h24, 1'b0, 32'h0, 0, 0, 9'h0, term);
    chk("lit_term_unmap", 32'(term), 32'd1);
    do_txn(Base + 32'h30, 1'b0, 32'h0, 0, 0, 9'h0, term);
    chk("lit_status_unmap", wb_din_o, 32'h2);

    // Abort in WAIT with a late core ack, then a CMD write.
    do_txn(Base + 32'h10, 1'b1, 32'h0000_0077, 4, 3, 9'h0, term);
    do_txn(Base + 32'h20, 1'b1, 32'h0000_0042, 1, 0, 9'h0, term);
    chk("lit_dout_cmd", 32'(dout_o), 32'h042);

    // Reset for two cycles while in WAIT.
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    wb_we_i   = 1'b0;
    wb_addr_i = Base + 32'h10;
    wb_dout_i = 32'h0000_0555;
    next_cycle();
    e_rd   = 1'b1;
    m_dout = 11'h555;
    next_cycle();
    e_rd = 1'b0;
    next_cycle();
    rst_i = 1'b1;
    set_idle();
    next_cycle();
    m_din   = 32'h0;
    m_dout  = '0;
    m_to    = 1'b0;
    m_unmap = 1'b0;
    next_cycle();
    rst_i = 1'b0;
    do_txn(Base + 32'h10, 1'b1, 32'h0000_0321, 1, 0, 9'h0, term);
    chk("lit_dout_post_rst", 32'(dout_o), 32'h321);

    // Randomised traffic with back-to-back requests and idle gaps.
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1:    addr = Base + 32'h10;
        2:       addr = Base + 32'h20;
        3, 4:    addr = Base + 32'h30;
        5:       addr = Base + 32'h24;
        6:       addr = Base + 32'h14;
        default: addr = $urandom;
      endcase
      k = $urandom_range(0, Tmo + 2);
      if (k == int'(Tmo) + 2) k = -1;
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 8) : 0;
      do_txn(addr, 1'($urandom), $urandom, k, ab, DinW'($urandom), term);
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
